shift_unit_mc: RTL and testbench
================================

# shift_unit_mc

Parametrised multi-cycle shift unit for the multi-cycle CPU datapath; the successor to the single-cycle 32-bit logical right shifter. Supports SLL, SRL, SRA and ROR over a configurable word width. It shifts at most STEP bit positions per clock and uses a start/busy/done handshake with the control FSM. The result is registered and held until the next accepted operation.

## Interface
- WIDTH, 32: data width; power of two, at least 8.
- STEP, 1: maximum bit positions shifted per cycle; power of two, at most WIDTH.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when `busy`=0.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- A  in  WIDTH  operand; captured when `start` is accepted.
- shift  in  SHW  shift amount, 0..WIDTH-1; captured when `start` is accepted.
- busy  out  1  high while the unit is in RUN.
- done  out  1  one-cycle pulse; `res` is valid from this cycle onward.
- res  out  WIDTH  registered result.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Internal registers: work[WIDTH], rem[SHW], op_q[2].
- Accept condition: `start`=1 in IDLE or DONE. On acceptance, work←A, rem←shift, op_q←op.
  - If shift=0, go to DONE.
  - Otherwise go to RUN.
- RUN, each cycle:
  - k = min(STEP, rem).
  - work ← one-step shift of work by k using op_q.
  - rem ← rem−k.
  - When rem−k = 0, go to DONE and load res ← shifted value.
- Shift semantics:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the original A[WIDTH-1] on every step.
  - ROR: bits leaving the LSB re-enter at the MSB.
- For shift=0, res←A unchanged for every op.
- DONE lasts one cycle with `done`=1.
  - Next state is IDLE, or a new accept if `start`=1 (back-to-back, no bubble).
- `start` while in RUN is ignored and not queued. A/op/shift changes during RUN have no effect.
- `res` changes only on the DONE-entry edge and on reset. It holds through IDLE and through the RUN of the next operation.
- Reset values: state=IDLE, busy=0, done=0, res=0, work=0, rem=0, op_q=0.
- Reset mid-operation aborts immediately: no `done` pulse and no partial result on `res`.

## Timing
- `start` accepted at edge t, with N = ceil(shift/STEP):
  - N=0: `done`=1 in cycle t+1; `busy` never rises.
  - N≥1: `busy`=1 in cycles t+1..t+N; `done`=1 and `busy`=0 in cycle t+N+1.
- Worst-case latency is ceil((WIDTH−1)/STEP)+1 cycles; 32 cycles for WIDTH=32, STEP=1.
- `done` and `busy` are never high simultaneously.
- Back-to-back: `start` held high in the DONE cycle launches the next operation on that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `shift_pkg`:
  - op encodings OP_SLL/OP_SRL/OP_SRA/OP_ROR.
  - State enum ST_IDLE/ST_RUN/ST_DONE.
- Sub-module `shift_step`: combinational, shifts WIDTH bits by an amount 0..STEP according to op, with an sra_fill input. Instantiated once.
- Top level holds the FSM, work/rem/op_q/res registers and the handshake.

## Test plan
- WIDTH=32, STEP=1: A=0x8000_00F0, op=SRA, shift=4 → busy cycles t+1..t+4; done at t+5; res=0xF800_000F.
- STEP=4: A=0x1234_5678, op=ROR, shift=9 → N=3; done at t+4; res=0x3C09_1A2B.
- shift=0, op=SLL, A=0xDEAD_BEEF → done at t+1; busy never high; res=0xDEAD_BEEF.
- SLL A=0x0000_0001 shift=31 (STEP=1) → done at t+32, res=0x8000_0000. `start` pulsed at t+10 with other data is ignored.
- Back-to-back: hold `start` in the DONE cycle with SRL A=0xFFFF_FFFF shift=8 → second done 9 cycles later, res=0x00FF_FFFF. The first res is held until then.
- rst asserted at t+2 of a shift=20 operation → next cycle busy=0, done=0, res=0; no done pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit.
// Op codes match the 2-bit op field of the datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions.
// SRA fills from sra_fill; ROR wraps LSBs back into the MSB.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 6
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  op_e              op,
  input  logic             sra_fill,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] ext_sh;

  always_comb begin
    ext = {WIDTH'(0), data};
    unique case (1'b1)
      (op == OP_SRA): ext = {{WIDTH{sra_fill}}, data};
      (op == OP_ROR): ext = {data, data};
      default:        ext = {WIDTH'(0), data};
    endcase
  end

  assign ext_sh = ext >> amt;

  always_comb begin
    y = ext_sh[WIDTH-1:0];
    unique case (1'b1)
      (op == OP_SLL): y = data << amt;
      default:        y = ext_sh[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle SLL/SRL/SRA/ROR unit, at most STEP bits per clock.
// Start/busy/done handshake; res is held until the next done.
module shift_unit_mc
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int KW = SHW + 1;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  op_e              op_q;
  logic [KW-1:0]    k;
  logic [SHW-1:0]   rem_nx;
  logic [WIDTH-1:0] step_y;
  logic             accept;

  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    k = KW'(STEP);
    if ({1'b0, rem} < KW'(STEP)) k = {1'b0, rem};
  end

  assign rem_nx = rem - k[SHW-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .AW    (KW)
  ) u_step (
    .data     (work),
    .amt      (k),
    .op       (op_q),
    .sra_fill (work[WIDTH-1]),
    .y        (step_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: if (rem_nx == '0) state_d = ST_DONE;
      default: begin
        state_d = ST_IDLE;
        if (start) state_d = (shift == '0) ? ST_DONE : ST_RUN;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // SRA keeps the sign in work's MSB, so it serves as the fill each step
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      rem  <= '0;
      op_q <= OP_SLL;
      res  <= '0;
    end else if (accept) begin
      work <= A;
      rem  <= shift;
      op_q <= op_e'(op);
      if (shift == '0) res <= A;
    end else if (state_q == ST_RUN) begin
      work <= step_y;
      rem  <= rem_nx;
      if (rem_nx == '0) res <= step_y;
    end
  end

endmodule

// File: tb/tb_shift_unit_mc.sv
// Bench for shift_unit_mc: STEP=1 and STEP=4 instances,
// directed and random ops against an arithmetic model.
module tb_shift_unit_mc;

  logic        clk;
  logic        rst;
  logic        start0, start4;
  logic [1:0]  op0, op4;
  logic [31:0] a0, a4;
  logic [4:0]  sh0, sh4;
  logic        busy0, busy4;
  logic        done0, done4;
  logic [31:0] res0, res4;

  int checks = 0;
  int errors = 0;

  shift_unit_mc #(.WIDTH(32), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0),
    .A(a0), .shift(sh0), .busy(busy0), .done(done0), .res(res0)
  );

  shift_unit_mc #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4),
    .A(a4), .shift(sh4), .busy(busy4), .done(done4), .res(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [1:0] o, input logic [31:0] a, input int sh);
    logic [31:0] r;
    case (o)
      2'd0: r = a << sh;
      2'd1: r = a >> sh;
      2'd2: r = $signed(a) >>> sh;
      default: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic s, input logic [1:0] o,
                       input logic [31:0] a, input logic [4:0] sh);
    if (u == 0) begin
      start0 = s; op0 = o; a0 = a; sh0 = sh;
    end else begin
      start4 = s; op4 = o; a4 = a; sh4 = sh;
    end
  endtask

  function automatic logic [33:0] outs(input int u);
    return (u == 0) ? {busy0, done0, res0} : {busy4, done4, res4};
  endfunction

  // Start accepted on the next edge; ends sampling in the done cycle.
  task automatic run(input string tag, input int u, input logic [1:0] o,
                     input logic [31:0] a, input int sh, input int ign_at);
    int stp;
    int n;
    logic [31:0] exp;
    logic [31:0] prev;
    logic [33:0] ob;
    stp  = (u == 0) ? 1 : 4;
    n    = (sh + stp - 1) / stp;
    exp  = model(o, a, sh);
    ob   = outs(u);
    prev = ob[31:0];
    drive(u, 1'b1, o, a, 5'(sh));
    @(posedge clk); #1;
    drive(u, 1'b0, o, a, 5'(sh));
    for (int c = 1; c <= n + 1; c++) begin
      ob = outs(u);
      chk({tag, ".busy"}, 32'(ob[33]), 32'(c <= n));
      chk({tag, ".done"}, 32'(ob[32]), 32'(c == n + 1));
      chk({tag, ".res"}, ob[31:0], (c <= n) ? prev : exp);
      if (c == ign_at) drive(u, 1'b1, ~o, ~a, ~5'(sh));
      else             drive(u, 1'b0, ~o, ~a, ~5'(sh));
      if (c <= n) begin
        @(posedge clk); #1;
      end
    end
    drive(u, 1'b0, o, a, 5'(sh));
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [33:0] ob;
    bit saw_done;
    rst = 1'b1;
    drive(0, 1'b0, 2'd0, 32'h0, 5'd0);
    drive(4, 1'b0, 2'd0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 8; u += 4) begin
      ob = outs(u);
      chk("reset.busy", 32'(ob[33]), 32'd0);
      chk("reset.done", 32'(ob[32]), 32'd0);
      chk("reset.res", ob[31:0], 32'd0);
    end
    rst = 1'b0;
    idle();

    run("sra4", 0, 2'd2, 32'h8000_00F0, 4, 0);
    chk("sra4.val", res0, 32'hF800_000F);
    idle();
    run("ror9", 4, 2'd3, 32'h1234_5678, 9, 0);
    chk("ror9.val", res4, 32'h3C09_1A2B);
    idle();
    run("zero", 0, 2'd0, 32'hDEAD_BEEF, 0, 0);
    chk("zero.val", res0, 32'hDEAD_BEEF);
    idle();
    run("sll31", 0, 2'd0, 32'h0000_0001, 31, 10);
    chk("sll31.val", res0, 32'h8000_0000);
    // Back-to-back: second run starts in the first one's done cycle
    run("b2b.srl", 0, 2'd1, 32'hFFFF_FFFF, 8, 0);
    chk("b2b.val", res0, 32'h00FF_FFFF);
    idle();

    for (int i = 0; i < 24; i++) begin
      int u;
      u = (i % 2 == 0) ? 0 : 4;
      run($sformatf("rnd%0d", i), u, 2'($urandom_range(0, 3)),
          $urandom, int'($urandom_range(0, 31)),
          int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    drive(0, 1'b1, 2'd1, 32'hCAFE_F00D, 5'd20);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'd1, 32'hCAFE_F00D, 5'd20);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", 32'(busy0), 32'd0);
    chk("abort.done", 32'(done0), 32'd0);
    chk("abort.res", res0, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (done0 || busy0) saw_done = 1'b1;
      idle();
    end
    chk("abort.quiet", 32'(saw_done), 32'd0);
    chk("abort.hold", res0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
